// File: rtl/delay_buffer_pkg.sv
// Shared constants and helpers for the delay_buffer block.
package delay_buffer_pkg;

    localparam int DefaultWidth = 8;
    localparam int DefaultDepth = 1;
    localparam int MaxDepth     = 64;

    // True when a width/depth pair can be built.
    function automatic bit params_ok(input int width, input int depth);
        return (width >= 1) && (depth >= 1) && (depth <= MaxDepth);
    endfunction

endpackage

// File: rtl/buffer_stage.sv
// One Width-bit pipeline register with synchronous reset to ResetValue.
module buffer_stage
    import delay_buffer_pkg::*;
#(
    parameter int               Width      = DefaultWidth,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    // Capture the incoming word, or the reset value while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= ResetValue;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/delay_buffer.sv
// Fixed-latency data buffer: a chain of Depth registers between d_i and q_o.
// No handshake; one word enters and one word leaves on every rising edge.
module delay_buffer
    import delay_buffer_pkg::*;
#(
    parameter int               Width      = DefaultWidth,
    parameter int               Depth      = DefaultDepth,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    // Refuse to elaborate an unbuildable configuration.
    if (!params_ok(Width, Depth)) begin : g_param_check
        $fatal(1, "delay_buffer: illegal parameters Width=%0d Depth=%0d", Width, Depth);
    end

    // Register outputs of each stage; stage[Depth-1] is the buffer output.
    logic [Depth-1:0][Width-1:0] stage;

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        if (k == 0) begin : g_head
            buffer_stage #(
                .Width      (Width),
                .ResetValue (ResetValue)
            ) u_stage (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (d_i),
                .q_o   (stage[k])
            );
        end else begin : g_tail
            buffer_stage #(
                .Width      (Width),
                .ResetValue (ResetValue)
            ) u_stage (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (stage[k-1]),
                .q_o   (stage[k])
            );
        end
    end

    // Output comes straight from the last register, never from d_i.
    assign q_o = stage[Depth-1];

endmodule

// File: tb/tb_delay_buffer.sv
// Self-checking bench for delay_buffer across several width/depth configurations.
module tb_delay_buffer;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Width 8, Depth 1 (table-driven + ramp)
    logic       rst8;
    logic [7:0] d8, q8;
    // Shared reset for the remaining scoreboard-checked instances
    logic        rst_m;
    logic [7:0]  d4, q4;
    logic        d1, q1;
    logic [31:0] d32, q32;

    delay_buffer #(.Width(8), .Depth(1), .ResetValue(8'h00)) u_d1 (
        .clk_i(clk), .rst_i(rst8), .d_i(d8), .q_o(q8));
    delay_buffer #(.Width(8), .Depth(4), .ResetValue(8'h5A)) u_d4 (
        .clk_i(clk), .rst_i(rst_m), .d_i(d4), .q_o(q4));
    delay_buffer #(.Width(1), .Depth(3), .ResetValue(1'b0)) u_w1 (
        .clk_i(clk), .rst_i(rst_m), .d_i(d1), .q_o(q1));
    delay_buffer #(.Width(32), .Depth(2), .ResetValue(32'h0)) u_w32 (
        .clk_i(clk), .rst_i(rst_m), .d_i(d32), .q_o(q32));

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    logic [31:0] sb4  [$];
    logic [31:0] sb1  [$];
    logic [31:0] sb32 [$];
    logic [31:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected leading reset-value cycles after reset release.
    task automatic prime_sb();
        sb4.delete(); sb1.delete(); sb32.delete();
        repeat (3) sb4.push_back(32'h5A);
        repeat (2) sb1.push_back(32'h0);
        repeat (1) sb32.push_back(32'h0);
    endtask

    initial begin
        rst8 = 1'b1; d8 = 8'hFF;
        rst_m = 1'b1; d4 = 8'hFF; d1 = 1'b1; d32 = 32'hFFFF_FFFF;

        // Depth=1 directed vectors: q8 expected right after each edge.
        vecs[0] = '{1'b1, 8'hFF, 8'h00};
        vecs[1] = '{1'b1, 8'hFF, 8'h00};
        vecs[2] = '{1'b0, 8'hA5, 8'hA5};
        vecs[3] = '{1'b0, 8'h3C, 8'h3C};
        vecs[4] = '{1'b0, 8'h11, 8'h11};
        vecs[5] = '{1'b0, 8'h22, 8'h22};
        vecs[6] = '{1'b1, 8'h33, 8'h00};
        vecs[7] = '{1'b0, 8'h44, 8'h44};

        // Reset of the multi-stage instances runs alongside the first vectors.
        for (int i = 0; i < 8; i++) begin
            rst8 = vecs[i].rst;
            d8   = vecs[i].d;
            if (i == 2) rst_m = 1'b0;
            tick();
            chk($sformatf("d1_vec%0d", i), {24'h0, q8}, {24'h0, vecs[i].exp});
            if (i < 2) begin
                chk("d4_reset",  {24'h0, q4}, 32'h5A);
                chk("w1_reset",  {31'h0, q1}, 32'h0);
                chk("w32_reset", q32, 32'h0);
            end
            if (i == 1) prime_sb();
            if (i >= 2) begin
                sb4.push_back({24'h0, d4});
                sb1.push_back({31'h0, d1});
                sb32.push_back(d32);
                e = sb4.pop_front();  chk("d4_hold",  {24'h0, q4}, e);
                e = sb1.pop_front();  chk("w1_hold",  {31'h0, q1}, e);
                e = sb32.pop_front(); chk("w32_hold", q32, e);
            end
        end

        // Depth=1 streaming ramp: every value once, in order.
        for (int i = 0; i < 256; i++) begin
            d8 = 8'(i);
            tick();
            chk("d1_ramp", {24'h0, q8}, i);
        end

        // Restart the multi-stage instances cleanly, then stream.
        rst_m = 1'b1;
        tick();
        chk("d4_rst2", {24'h0, q4}, 32'h5A);
        rst_m = 1'b0;
        prime_sb();
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                // Mid-stream reset: in-flight words must vanish.
                rst_m = 1'b1;
                d4 = 8'h77; d1 = 1'b1; d32 = 32'hCAFE_F00D;
                tick();
                chk("d4_midrst",  {24'h0, q4}, 32'h5A);
                chk("w1_midrst",  {31'h0, q1}, 32'h0);
                chk("w32_midrst", q32, 32'h0);
                rst_m = 1'b0;
                prime_sb();
            end
            d4  = (i < 3) ? 8'(i + 1) : 8'($urandom);
            d1  = i[0];
            d32 = (i == 0 || i == 21) ? 32'hDEAD_BEEF : $urandom;
            sb4.push_back({24'h0, d4});
            sb1.push_back({31'h0, d1});
            sb32.push_back(d32);
            tick();
            if (sb4.size() == 0 || sb1.size() == 0 || sb32.size() == 0) begin
                chk("sb_underflow", 32'h1, 32'h0);
            end else begin
                e = sb4.pop_front();  chk("d4_stream",  {24'h0, q4}, e);
                e = sb1.pop_front();  chk("w1_stream",  {31'h0, q1}, e);
                e = sb32.pop_front(); chk("w32_stream", q32, e);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
